// File: rtl/enlarge.sv
// Nearest-neighbour up-sampler: streams a WIDTH x HIEGHT source frame out as a
// (WIDTH*FACTOR) x (HIEGHT*FACTOR) frame, one output pixel per clock.
module enlarge #(
   parameter int FACTOR = 2,
   parameter int BPP    = 3,
   parameter int WIDTH  = 30,
   parameter int HIEGHT = 30,
   localparam int PEXILS  = WIDTH * HIEGHT,
   localparam int ADDR_WR = PEXILS * FACTOR * FACTOR
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [8*BPP-1:0]           pexil_in,
   output logic [8*BPP-1:0]           pexil_out,
   output logic                       wr_en,
   output logic                       done,
   output logic [$clog2(ADDR_WR)-1:0] write_adrr,
   output logic [$clog2(PEXILS)-1:0]  read_adrr
);

   localparam int WA  = $clog2(ADDR_WR);
   localparam int RA  = $clog2(PEXILS);
   localparam int FW  = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam int SXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int SYW = (HIEGHT > 1) ? $clog2(HIEGHT) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e           state_q, state_d;
   logic [FW-1:0]    fx_q, fx_d, fy_q, fy_d;
   logic [SXW-1:0]   sx_q, sx_d;
   logic [SYW-1:0]   sy_q, sy_d;
   logic [RA-1:0]    base_q, base_d;
   logic [WA-1:0]    k_q, k_d;
   logic             flush_q, flush_d;
   logic             v1_q, v1_d;
   logic [WA-1:0]    wa1_q, wa1_d;
   logic [RA-1:0]    read_adrr_q, read_adrr_d;
   logic [WA-1:0]    write_adrr_q, write_adrr_d;
   logic [8*BPP-1:0] pexil_out_q, pexil_out_d;
   logic             wr_en_q, wr_en_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      base_d  = base_q;
      k_d     = k_q;
      flush_d = 1'b0;
      v1_d    = 1'b0;
      wa1_d   = k_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            v1_d = 1'b1;
            k_d  = k_q + WA'(1);
            // Odometer: column phase, source column, row phase, source row.
            if (fx_q == FW'(FACTOR - 1)) begin
               fx_d = '0;
               if (sx_q == SXW'(WIDTH - 1)) begin
                  sx_d = '0;
                  if (fy_q == FW'(FACTOR - 1)) begin
                     fy_d = '0;
                     if (sy_q == SYW'(HIEGHT - 1)) begin
                        sy_d    = '0;
                        base_d  = '0;
                        k_d     = '0;
                        state_d = StFlush;
                     end else begin
                        sy_d   = sy_q + SYW'(1);
                        base_d = base_q + RA'(WIDTH);
                     end
                  end else begin
                     fy_d = fy_q + FW'(1);
                  end
               end else begin
                  sx_d = sx_q + SXW'(1);
               end
            end else begin
               fx_d = fx_q + FW'(1);
            end
         end
         StFlush: begin
            flush_d = ~flush_q;
            if (flush_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      read_adrr_d  = base_d + RA'(sx_d);
      // Stage 2: pixel arrives one cycle after its address; register it with its write address.
      wr_en_d      = v1_q;
      write_adrr_d = v1_q ? wa1_q : write_adrr_q;
      pexil_out_d  = v1_q ? pexil_in : pexil_out_q;
      done_d       = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         fx_q         <= '0;
         fy_q         <= '0;
         sx_q         <= '0;
         sy_q         <= '0;
         base_q       <= '0;
         k_q          <= '0;
         flush_q      <= 1'b0;
         v1_q         <= 1'b0;
         wa1_q        <= '0;
         read_adrr_q  <= '0;
         write_adrr_q <= '0;
         pexil_out_q  <= '0;
         wr_en_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fx_q         <= fx_d;
         fy_q         <= fy_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         base_q       <= base_d;
         k_q          <= k_d;
         flush_q      <= flush_d;
         v1_q         <= v1_d;
         wa1_q        <= wa1_d;
         read_adrr_q  <= read_adrr_d;
         write_adrr_q <= write_adrr_d;
         pexil_out_q  <= pexil_out_d;
         wr_en_q      <= wr_en_d;
         done_q       <= done_d;
      end
   end

   assign read_adrr  = read_adrr_q;
   assign write_adrr = write_adrr_q;
   assign pexil_out  = pexil_out_q;
   assign wr_en      = wr_en_q;
   assign done       = done_q;

endmodule
